lcd_driver: RTL and testbench
=============================

Name: lcd_driver

Overview:
- Timing generator for a 480x272 parallel-RGB TFT panel, clocked by the pixel clock (nominally 4.5 MHz, 222.222 ns period).
- Produces active-low HSYNC and VSYNC, the DEN data-enable strobe, and the current active-pixel coordinates XPOS/YPOS.
- Pixel-colour logic downstream uses XPOS/YPOS/DEN to drive LCD_R/G/B; colour generation is outside this block.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, HSYNC pulse width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, VSYNC pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- Derived: H_TOTAL = 525 clocks; V_TOTAL = 286 lines; one frame = 150150 clocks.

Ports:
- VGA_CLK, input, 1, pixel clock; all logic on rising edge
- RESETn, input, 1, reset, synchronous, active-low
- HSYNC, output, 1, horizontal sync, active low
- VSYNC, output, 1, vertical sync, active low
- DEN, output, 1, data enable, high during visible pixels
- XPOS, output, 10, visible pixel column 0..479
- YPOS, output, 10, visible line 0..271

Behaviour:
- Internal counters: hcnt, 10 bits, 0..H_TOTAL-1; vcnt, 9 bits min (10 allowed), 0..V_TOTAL-1.
- Reset (RESETn low at a rising edge):
  - hcnt = vcnt = 0.
  - HSYNC = 1, VSYNC = 1, DEN = 0, XPOS = 0, YPOS = 0.
  - Reset asserted mid-frame takes effect on that edge and restarts the frame.
- Each rising edge with RESETn high:
  - All outputs are registered decodes of the current (hcnt, vcnt); the counters then advance. Outputs therefore lag the counters by exactly one clock.
  - The first edge after reset release presents (hcnt, vcnt) = (0, 0).
- Counter advance:
  - hcnt increments each clock.
  - At hcnt = H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - At vcnt = V_TOTAL-1 together with the hcnt wrap, vcnt wraps to 0.
- Line layout in hcnt: sync [0,41), back porch [41,43), active [43,523), front porch [523,525).
- Frame layout in vcnt: sync [0,10), back porch [10,12), active [12,284), front porch [284,286).
- HSYNC = 0 when hcnt < H_SYNC, otherwise 1.
- VSYNC = 0 when vcnt < V_SYNC, otherwise 1. VSYNC changes only at line boundaries, i.e. on the same edge HSYNC falls.
- DEN = 1 only when both hcnt and vcnt are in their active ranges.
- XPOS = hcnt - (H_SYNC+H_BP) when DEN is 1, otherwise 0.
- YPOS = vcnt - (V_SYNC+V_BP) when vcnt is in the active range, otherwise 0. YPOS holds its line value across that line's blanking.
- No other inputs; the block free-runs from reset.
- Arithmetic: unsigned; subtraction results are always in range, no saturation needed.

Decomposition:
- Shared package lcd_timing_pkg holds:
  - the eight timing constants and derived H_TOTAL, V_TOTAL;
  - start/end region constants (H_ACT_START = 43, H_ACT_END = 523, V_ACT_START = 12, V_ACT_END = 284).
- One natural sub-module, lcd_axis_timing: a wrapping counter with sync/active decode, parameterised by (ACTIVE, FP, SYNC, BP).
  - Instantiated twice: horizontal, enabled every clock; vertical, enabled by the horizontal wrap pulse.

Test Plan:
- Reset hold: RESETn low 10 clocks -> HSYNC=1, VSYNC=1, DEN=0, XPOS=0, YPOS=0 throughout. First edge after release -> HSYNC=0, VSYNC=0.
- Horizontal timing: measure over 3 lines.
  - HSYNC low exactly 41 clocks per 525-clock period.
  - DEN high 480 consecutive clocks starting 43 clocks after each HSYNC fall, on active lines.
- Vertical timing:
  - VSYNC low exactly 10 lines (5250 clocks); VSYNC period 150150 clocks.
  - VSYNC falling edges coincide with HSYNC falling edges.
  - DEN never high on the first 12 or last 2 lines.
- Coordinates:
  - XPOS counts 0..479 contiguously while DEN=1.
  - YPOS = 0 on the first active line and 271 on the last.
  - XPOS and YPOS equal 0 while DEN=0 outside the active lines.
- Wrap: across the frame boundary (last front-porch clock -> next frame) there is no glitch. Exactly 272x480 = 130560 DEN cycles per frame, checked over 2 consecutive frames (about 70 ms of simulation).
- Mid-frame reset: assert RESETn low for 1 clock at line 100, column 200 -> outputs take reset values on that edge, and the next frame starts from (0,0) with full timing.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
//------------------------------------------------------------------------------
// lcd_timing_pkg
//   Timing constants for a 480x272 parallel-RGB TFT panel: porch and sync
//   widths, derived totals and active-region boundaries.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lcd_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_ACTIVE = 480;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 41;
    localparam int H_BP     = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int V_ACTIVE = 272;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 10;
    localparam int V_BP     = 2;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries: each line/frame is laid out as sync, back porch,
    // active, front porch, starting at count 0.
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    // Width of the internal counters and of the coordinate outputs
    localparam int COORD_W = 10;

endpackage : lcd_timing_pkg

`default_nettype wire

// File: rtl/lcd_axis_timing.sv
//------------------------------------------------------------------------------
// lcd_axis_timing
//   Wrapping position counter for one display axis, with combinational
//   decode of the sync and active regions of the current count.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lcd_axis_timing #(
    parameter int ACTIVE = 480,
    parameter int FP     = 2,
    parameter int SYNC   = 41,
    parameter int BP     = 2,
    parameter int WIDTH  = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_active
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [WIDTH-1:0] LAST      = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] SYNC_END  = WIDTH'(SYNC);
    localparam logic [WIDTH-1:0] ACT_START = WIDTH'(SYNC + BP);
    localparam logic [WIDTH-1:0] ACT_END   = WIDTH'(SYNC + BP + ACTIVE);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    // Position counter: advances when enabled, wraps after the last position
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

    // Wrap pulse only on an enabled step, so the next axis advances once
    assign wrap      = en && (count == LAST);
    assign in_sync   = (count < SYNC_END);
    assign in_active = (count >= ACT_START) && (count < ACT_END);

endmodule : lcd_axis_timing

`default_nettype wire

// File: rtl/lcd_driver.sv
//------------------------------------------------------------------------------
// lcd_driver
//   Free-running HSYNC/VSYNC/DEN timing generator for a parallel-RGB TFT,
//   with registered visible-pixel coordinates. Outputs are registered decodes
//   of the counter state, so they lag the counters by one pixel clock.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lcd_driver
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = lcd_timing_pkg::H_ACTIVE,
    parameter int H_FP     = lcd_timing_pkg::H_FP,
    parameter int H_SYNC   = lcd_timing_pkg::H_SYNC,
    parameter int H_BP     = lcd_timing_pkg::H_BP,
    parameter int V_ACTIVE = lcd_timing_pkg::V_ACTIVE,
    parameter int V_FP     = lcd_timing_pkg::V_FP,
    parameter int V_SYNC   = lcd_timing_pkg::V_SYNC,
    parameter int V_BP     = lcd_timing_pkg::V_BP
) (
    input  logic               VGA_CLK,
    input  logic               RESETn,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               DEN,
    output logic [COORD_W-1:0] XPOS,
    output logic [COORD_W-1:0] YPOS
);

    // First active count on each axis, used to turn counts into coordinates
    localparam logic [COORD_W-1:0] X_ORIGIN = COORD_W'(H_SYNC + H_BP);
    localparam logic [COORD_W-1:0] Y_ORIGIN = COORD_W'(V_SYNC + V_BP);

    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_sync;
    logic               v_sync;
    logic               h_active;
    logic               v_active;
    logic               den_next;

    // Horizontal axis steps on every pixel clock
    lcd_axis_timing #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .WIDTH  (COORD_W)
    ) u_h_axis (
        .clk       (VGA_CLK),
        .resetn    (RESETn),
        .en        (1'b1),
        .count     (h_count),
        .wrap      (h_wrap),
        .in_sync   (h_sync),
        .in_active (h_active)
    );

    // Vertical axis steps once per line, on the horizontal wrap
    lcd_axis_timing #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .WIDTH  (COORD_W)
    ) u_v_axis (
        .clk       (VGA_CLK),
        .resetn    (RESETn),
        .en        (h_wrap),
        .count     (v_count),
        .wrap      (v_wrap),
        .in_sync   (v_sync),
        .in_active (v_active)
    );

    assign den_next = h_active && v_active;

    // Register the decode of the current counter state onto the panel pins
    always_ff @(posedge VGA_CLK) begin
        if (!RESETn) begin
            HSYNC <= 1'b1;
            VSYNC <= 1'b1;
            DEN   <= 1'b0;
            XPOS  <= '0;
            YPOS  <= '0;
        end else begin
            HSYNC <= ~h_sync;
            VSYNC <= ~v_sync;
            DEN   <= den_next;
            // Column is only meaningful while data is enabled
            XPOS  <= den_next ? (h_count - X_ORIGIN) : '0;
            // Line number holds through that line's horizontal blanking
            YPOS  <= v_active ? (v_count - Y_ORIGIN) : '0;
        end
    end

endmodule : lcd_driver

`default_nettype wire

// File: tb/tb_lcd_driver.sv
//------------------------------------------------------------------------------
// tb_lcd_driver
//   Self-checking bench: full-size panel timing plus a reduced-size instance
//   that cycles through many frames with random reset pulses.
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_driver;

    logic       clk;
    logic       rstn_b;
    logic       rstn_s;

    logic       b_hsync, b_vsync, b_den;
    logic [9:0] b_xpos, b_ypos;
    logic       s_hsync, s_vsync, s_den;
    logic [9:0] s_xpos, s_ypos;

    int checks = 0;
    int errors = 0;

    // Timing per instance: index 0 full panel, index 1 reduced
    int ha [2] = '{480, 8};
    int hfp[2] = '{2, 1};
    int hs [2] = '{41, 3};
    int hb [2] = '{2, 2};
    int va [2] = '{272, 5};
    int vfp[2] = '{2, 1};
    int vs [2] = '{10, 2};
    int vb [2] = '{2, 1};

    // Model state: clocks since reset release (-1 while held in reset)
    int pos[2] = '{-1, -1};

    // Interval trackers
    int hs_fall_t[2], den_rise_t[2], vs_fall_t[2], den_cnt[2];
    bit hs_valid[2], den_valid[2], vs_valid[2];
    logic prev_hs[2], prev_vs[2], prev_den[2];

    int s_hold = 0;

    lcd_driver dut (
        .VGA_CLK (clk),
        .RESETn  (rstn_b),
        .HSYNC   (b_hsync),
        .VSYNC   (b_vsync),
        .DEN     (b_den),
        .XPOS    (b_xpos),
        .YPOS    (b_ypos)
    );

    lcd_driver #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (5), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_s (
        .VGA_CLK (clk),
        .RESETn  (rstn_s),
        .HSYNC   (s_hsync),
        .VSYNC   (s_vsync),
        .DEN     (s_den),
        .XPOS    (s_xpos),
        .YPOS    (s_ypos)
    );

    initial clk = 1'b0;
    always #111 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected panel outputs at a given number of clocks since reset release
    function automatic void model(input int i, input int p,
                                  output int e_hs, output int e_vs, output int e_den,
                                  output int e_x, output int e_y);
        int ht, vt, hc, vc, hact, vact;
        if (p < 0) begin
            e_hs = 1; e_vs = 1; e_den = 0; e_x = 0; e_y = 0;
            return;
        end
        ht   = ha[i] + hfp[i] + hs[i] + hb[i];
        vt   = va[i] + vfp[i] + vs[i] + vb[i];
        hc   = p % ht;
        vc   = (p / ht) % vt;
        hact = (hc >= hs[i] + hb[i] && hc < hs[i] + hb[i] + ha[i]) ? 1 : 0;
        vact = (vc >= vs[i] + vb[i] && vc < vs[i] + vb[i] + va[i]) ? 1 : 0;
        e_hs  = (hc < hs[i]) ? 0 : 1;
        e_vs  = (vc < vs[i]) ? 0 : 1;
        e_den = hact & vact;
        e_x   = e_den ? hc - (hs[i] + hb[i]) : 0;
        e_y   = vact ? vc - (vs[i] + vb[i]) : 0;
    endfunction

    task automatic check_inst(input int i);
        logic o_hs, o_vs, o_den;
        int   o_x, o_y, e_hs, e_vs, e_den, e_x, e_y, t, ht;
        bit   hs_fell;
        string n;
        n = (i == 0) ? "full" : "small";
        if (i == 0) begin
            o_hs = b_hsync; o_vs = b_vsync; o_den = b_den; o_x = int'(b_xpos); o_y = int'(b_ypos);
        end else begin
            o_hs = s_hsync; o_vs = s_vsync; o_den = s_den; o_x = int'(s_xpos); o_y = int'(s_ypos);
        end
        model(i, pos[i], e_hs, e_vs, e_den, e_x, e_y);
        chk({n, "_hsync"}, int'(o_hs), e_hs);
        chk({n, "_vsync"}, int'(o_vs), e_vs);
        chk({n, "_den"},   int'(o_den), e_den);
        chk({n, "_xpos"},  o_x, e_x);
        chk({n, "_ypos"},  o_y, e_y);

        t  = pos[i];
        ht = ha[i] + hfp[i] + hs[i] + hb[i];
        if (t < 0) begin
            hs_valid[i] = 0; den_valid[i] = 0; vs_valid[i] = 0;
        end else begin
            hs_fell = prev_hs[i] && !o_hs;
            if (hs_fell) begin
                if (hs_valid[i]) chk({n, "_h_period"}, t - hs_fall_t[i], ht);
                hs_fall_t[i] = t; hs_valid[i] = 1;
            end
            if (!prev_hs[i] && o_hs && hs_valid[i])
                chk({n, "_h_sync_len"}, t - hs_fall_t[i], hs[i]);
            if (!prev_den[i] && o_den) begin
                if (hs_valid[i]) chk({n, "_den_start"}, t - hs_fall_t[i], hs[i] + hb[i]);
                den_rise_t[i] = t; den_valid[i] = 1;
            end
            if (prev_den[i] && !o_den && den_valid[i])
                chk({n, "_den_len"}, t - den_rise_t[i], ha[i]);
            if (prev_vs[i] && !o_vs) begin
                chk({n, "_vs_on_hs_fall"}, int'(hs_fell), 1);
                if (vs_valid[i]) begin
                    chk({n, "_v_period"}, t - vs_fall_t[i],
                        ht * (va[i] + vfp[i] + vs[i] + vb[i]));
                    chk({n, "_den_per_frame"}, den_cnt[i], ha[i] * va[i]);
                end
                vs_fall_t[i] = t; vs_valid[i] = 1; den_cnt[i] = 0;
            end
            if (!prev_vs[i] && o_vs && vs_valid[i])
                chk({n, "_v_sync_len"}, t - vs_fall_t[i], vs[i] * ht);
            if (o_den) den_cnt[i]++;
        end
        prev_hs[i] = o_hs; prev_vs[i] = o_vs; prev_den[i] = o_den;
    endtask

    // Random short reset pulses on the reduced instance
    task automatic drive_small();
        if (s_hold > 0) begin
            rstn_s = 1'b0;
            s_hold--;
        end else begin
            rstn_s = 1'b1;
            if ($urandom_range(0, 499) == 0) s_hold = $urandom_range(1, 3);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (((i == 0) ? rstn_b : rstn_s) == 1'b0) pos[i] = -1;
            else pos[i] = pos[i] + 1;
        end
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_hs[i] = 1'b1; prev_vs[i] = 1'b1; prev_den[i] = 1'b0;
            hs_valid[i] = 0; den_valid[i] = 0; vs_valid[i] = 0;
            hs_fall_t[i] = 0; den_rise_t[i] = 0; vs_fall_t[i] = 0; den_cnt[i] = 0;
        end

        // Reset hold on both instances
        rstn_b = 1'b0;
        rstn_s = 1'b0;
        @(negedge clk);
        repeat (10) tick();

        // Release and run the full panel up to line 100, column 200
        rstn_b = 1'b1;
        rstn_s = 1'b1;
        while (pos[0] < 100 * 525 + 200 - 1) begin
            drive_small();
            tick();
        end

        // One-clock reset landing on (line 100, column 200)
        rstn_b = 1'b0;
        drive_small();
        tick();
        rstn_b = 1'b1;

        // Restarted frame: sync, porch and the first active lines
        repeat (7000) begin
            drive_small();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lcd_driver

`default_nettype wire
